// File: rtl/button_debouncer_if.sv
// Button pin and debounced status grouped as one bundle.
// master drives the raw pin and observes the result; slave is the debouncer.
interface button_debouncer_if;
  logic btn_raw;
  logic btn_level;
  logic busy;

  modport master (
    output btn_raw,
    input  btn_level,
    input  busy
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output busy
  );
endinterface

// File: rtl/button_debouncer.sv
// Button debouncer: two-flop synchronizer followed by a four-state
// qualification FSM. A new level is accepted only after it has held on the
// synchronized input for DEBOUNCE_CYCLES consecutive clocks; any bounce
// restarts qualification from zero.
//
// state        | meaning
// STABLE_LOW   | accepted level 0, watching for a rise
// WAIT_HIGH    | synchronized input is 1, qualifying the rise
// STABLE_HIGH  | accepted level 1, watching for a fall
// WAIT_LOW     | synchronized input is 0, qualifying the fall
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  button_debouncer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  logic             btn_in;
  logic             s1;
  logic             s2;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             busy_q;
  logic             busy_d;

  // Pull-up buttons are inverted here so everything downstream sees logical polarity.
  assign btn_in = bus.btn_raw ^ ACTIVE_LOW;

  // Two-flop synchronizer; reset to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; the counter only advances below CNT_LAST so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      STABLE_LOW: begin
        if (s2) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!s2) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  assign bus.btn_level = level_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: three instances share clk/rst
// (4-cycle active-high, 4-cycle active-low, 1-cycle active-high).
module tb_button_debouncer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  button_debouncer_if if_main ();
  button_debouncer_if if_al ();
  button_debouncer_if if_d1 ();

  button_debouncer #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if_main.slave)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk (clk),
    .rst (rst),
    .bus (if_al.slave)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(1), .ACTIVE_LOW(1'b0)) u_dut_d1 (
    .clk (clk),
    .rst (rst),
    .bus (if_d1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_main.btn_raw = 1'b0;
    if_al.btn_raw   = 1'b1;
    if_d1.btn_raw   = 1'b0;
    #2;
    idle(3);
    checks++;
    if (if_main.btn_level !== 1'b0 || if_main.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_main level=%b busy=%b required 0 0", if_main.btn_level, if_main.busy);
    end
    checks++;
    if (if_al.btn_level !== 1'b0 || if_al.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_active_low level=%b busy=%b required 0 0", if_al.btn_level, if_al.busy);
    end
    rst = 1'b0;
    idle(4);
    checks++;
    if (if_main.btn_level !== 1'b0 || if_main.busy !== 1'b0 ||
        if_al.btn_level !== 1'b0 || if_al.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle main=%b%b al=%b%b required 00 00",
               if_main.btn_level, if_main.busy, if_al.btn_level, if_al.busy);
    end
  endtask

  // Clean press: busy rises after edge 3, level after edge 7.
  task automatic test_clean_press();
    if_main.btn_raw = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (if_main.btn_level !== (k >= 7) || if_main.busy !== (k >= 3 && k < 7)) begin
        errors++;
        $display("FAIL clean_press edge=%0d level=%b busy=%b required %b %b",
                 k, if_main.btn_level, if_main.busy, k >= 7, k >= 3 && k < 7);
      end
    end
  endtask

  // Release from level 1: level falls after edge 7.
  task automatic test_release();
    if_main.btn_raw = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (if_main.btn_level !== (k < 7) || if_main.busy !== (k >= 3 && k < 7)) begin
        errors++;
        $display("FAIL release edge=%0d level=%b busy=%b required %b %b",
                 k, if_main.btn_level, if_main.busy, k < 7, k >= 3 && k < 7);
      end
    end
  endtask

  // High 3 clocks, low 1, high held: qualification restarts, level rises at edge 11.
  task automatic test_bounce();
    logic exp_busy;
    for (int k = 1; k <= 13; k++) begin
      if_main.btn_raw = (k != 4);
      step();
      exp_busy = (k >= 3 && k <= 5) || (k >= 7 && k <= 10);
      checks++;
      if (if_main.btn_level !== (k >= 11) || if_main.busy !== exp_busy) begin
        errors++;
        $display("FAIL bounce edge=%0d level=%b busy=%b required %b %b",
                 k, if_main.btn_level, if_main.busy, k >= 11, exp_busy);
      end
    end
  endtask

  // High for 2 clocks only: busy pulses after edges 3 and 4, level never moves.
  task automatic test_short_glitch();
    for (int k = 1; k <= 12; k++) begin
      if_main.btn_raw = (k <= 2);
      step();
      checks++;
      if (if_main.btn_level !== 1'b0 || if_main.busy !== (k == 3 || k == 4)) begin
        errors++;
        $display("FAIL short_glitch edge=%0d level=%b busy=%b required 0 %b",
                 k, if_main.btn_level, if_main.busy, k == 3 || k == 4);
      end
    end
  endtask

  // Reset 2 clocks into WAIT_HIGH, then re-qualify with the button still held.
  task automatic test_mid_reset();
    if_main.btn_raw = 1'b1;
    idle(5);
    checks++;
    if (if_main.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre busy=%b required 1", if_main.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (if_main.btn_level !== 1'b0 || if_main.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async level=%b busy=%b required 0 0", if_main.btn_level, if_main.busy);
    end
    step();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (if_main.btn_level !== (k >= 7) || if_main.busy !== (k >= 3 && k < 7)) begin
        errors++;
        $display("FAIL mid_reset_requal edge=%0d level=%b busy=%b required %b %b",
                 k, if_main.btn_level, if_main.busy, k >= 7, k >= 3 && k < 7);
      end
    end
  endtask

  // Pull-up button: pin falling is a press.
  task automatic test_active_low();
    checks++;
    if (if_al.btn_level !== 1'b0) begin
      errors++;
      $display("FAIL active_low_idle level=%b required 0", if_al.btn_level);
    end
    if_al.btn_raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (if_al.btn_level !== (k >= 7) || if_al.busy !== (k >= 3 && k < 7)) begin
        errors++;
        $display("FAIL active_low_press edge=%0d level=%b busy=%b required %b %b",
                 k, if_al.btn_level, if_al.busy, k >= 7, k >= 3 && k < 7);
      end
    end
  endtask

  // One-cycle qualification: a single WAIT cycle, level after edge 4.
  task automatic test_min_cycles();
    if_d1.btn_raw = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (if_d1.btn_level !== (k >= 4) || if_d1.busy !== (k == 3)) begin
        errors++;
        $display("FAIL min_cycles_press edge=%0d level=%b busy=%b required %b %b",
                 k, if_d1.btn_level, if_d1.busy, k >= 4, k == 3);
      end
    end
    if_d1.btn_raw = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (if_d1.btn_level !== (k < 4) || if_d1.busy !== (k == 3)) begin
        errors++;
        $display("FAIL min_cycles_release edge=%0d level=%b busy=%b required %b %b",
                 k, if_d1.btn_level, if_d1.busy, k < 4, k == 3);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_release();
    idle(3);
    test_bounce();
    test_release();
    idle(3);
    test_short_glitch();
    test_mid_reset();
    test_active_low();
    test_min_cycles();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
